// File: rtl/dec2stch_bank_if.sv
// Handshake and stream bundle for dec2stch_bank: probability load side and
// the per-channel stochastic bit outputs.
interface dec2stch_bank_if #(
    parameter int ND  = 8,
    parameter int NCH = 4
);
    logic [NCH*ND-1:0] D;
    logic              LOAD;
    logic              READY;
    logic              EN;
    logic [NCH-1:0]    S;
    logic              VALID;
    logic              FRAME_END;

    modport master (output D, LOAD, EN, input READY, S, VALID, FRAME_END);
    modport slave  (input D, LOAD, EN, output READY, S, VALID, FRAME_END);
endinterface

// File: rtl/dec2stch_bank.sv
// Multi-channel decimal-to-stochastic converter: one shared maximal-length LFSR,
// per-channel rotated comparison, framed output of 2^ND-1 bits per channel.
module dec2stch_bank #(
    parameter int ND         = 8,
    parameter int NCH        = 4,
    parameter int SEED       = 1,
    parameter int ROT        = 3,
    parameter int CONTINUOUS = 0
) (
    input  logic           CLK,
    input  logic           INIT_N,
    dec2stch_bank_if.slave bus
);
    function automatic int tap_mask(input int n);
        case (n)
            4:       return 'h00C;
            5:       return 'h014;
            6:       return 'h030;
            7:       return 'h060;
            8:       return 'h0B8;
            10:      return 'h240;
            12:      return 'h829;
            default: return 0;
        endcase
    endfunction

    function automatic logic [ND-1:0] rotl(input logic [ND-1:0] x, input int r);
        logic [2*ND-1:0] w;
        w = {x, x} << r;
        return w[2*ND-1:ND];
    endfunction

    localparam int TAPS_I = tap_mask(ND);
    localparam int LAST_I = (1 << ND) - 2;
    localparam logic [ND-1:0] TAPS   = TAPS_I[ND-1:0];
    localparam logic [ND-1:0] LAST   = LAST_I[ND-1:0];
    localparam logic [ND-1:0] SEED_V = SEED[ND-1:0];

    if (TAPS_I == 0) begin : g_bad_nd
        $error("dec2stch_bank: unsupported ND=%0d", ND);
    end
    if (SEED <= 0 || SEED >= (1 << ND)) begin : g_bad_seed
        $error("dec2stch_bank: SEED=%0d out of range for ND=%0d", SEED, ND);
    end

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state_q, state_d;
    logic              ready_q, ready_d;
    logic [ND-1:0]     lfsr_q, lfsr_d;
    logic [ND-1:0]     cnt_q, cnt_d;
    logic [NCH*ND-1:0] dreg_q, dreg_d;
    logic [NCH*ND-1:0] shadow_q, shadow_d;
    logic              pend_q, pend_d;
    logic [NCH-1:0]    s_q, s_d;
    logic              vld_q, vld_d;
    logic              fe_q, fe_d;

    logic [NCH-1:0] cmp;
    logic [ND-1:0]  lfsr_nxt;
    logic           last;
    logic           accept;

    // Rotation is a bijection on 1..2^ND-1, so each channel sees every nonzero value once per frame.
    always_comb begin
        cmp = '0;
        for (int k = 0; k < NCH; k++)
            cmp[k] = dreg_q[k*ND +: ND] >= rotl(lfsr_q, (k * ROT) % ND);
    end

    assign lfsr_nxt = {lfsr_q[ND-2:0], ^(lfsr_q & TAPS)};
    assign last     = (cnt_q == LAST);
    assign accept   = bus.LOAD & ready_q;

    always_comb begin
        state_d  = state_q;
        lfsr_d   = lfsr_q;
        cnt_d    = cnt_q;
        dreg_d   = dreg_q;
        shadow_d = shadow_q;
        pend_d   = pend_q;
        s_d      = s_q;
        vld_d    = 1'b0;
        fe_d     = 1'b0;
        case (state_q)
            IDLE: begin
                s_d = '0;
                if (accept) begin
                    dreg_d  = bus.D;
                    lfsr_d  = SEED_V;
                    cnt_d   = '0;
                    pend_d  = 1'b0;
                    state_d = RUN;
                end
            end
            RUN: begin
                if (bus.EN) begin
                    s_d    = cmp;
                    vld_d  = 1'b1;
                    lfsr_d = lfsr_nxt;
                    cnt_d  = cnt_q + 1'b1;
                    if (last) begin
                        fe_d  = 1'b1;
                        cnt_d = '0;
                        if (CONTINUOUS == 0)
                            state_d = IDLE;
                    end
                end
                // Data for the next frame is only swapped at the frame boundary.
                if (CONTINUOUS != 0) begin
                    if (bus.EN && last) begin
                        if (accept)
                            dreg_d = bus.D;
                        else if (pend_q)
                            dreg_d = shadow_q;
                        pend_d = 1'b0;
                    end else if (accept) begin
                        shadow_d = bus.D;
                        pend_d   = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        ready_d = (state_d == IDLE) || (CONTINUOUS != 0);
    end

    always_ff @(posedge CLK) begin
        if (!INIT_N) begin
            state_q  <= IDLE;
            ready_q  <= 1'b1;
            lfsr_q   <= SEED_V;
            cnt_q    <= '0;
            dreg_q   <= '0;
            shadow_q <= '0;
            pend_q   <= 1'b0;
            s_q      <= '0;
            vld_q    <= 1'b0;
            fe_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            ready_q  <= ready_d;
            lfsr_q   <= lfsr_d;
            cnt_q    <= cnt_d;
            dreg_q   <= dreg_d;
            shadow_q <= shadow_d;
            pend_q   <= pend_d;
            s_q      <= s_d;
            vld_q    <= vld_d;
            fe_q     <= fe_d;
        end
    end

    assign bus.READY     = ready_q;
    assign bus.S         = s_q;
    assign bus.VALID     = vld_q;
    assign bus.FRAME_END = fe_q;
endmodule

// File: tb/tb_dec2stch_bank.sv
// Scoreboard bench for dec2stch_bank: a one-shot and a continuous instance,
// each checked bit-by-bit and per-frame ones count against a reference model.
module tb_dec2stch_bank;
    localparam int ND   = 8;
    localparam int NCH  = 2;
    localparam int SEED = 1;
    localparam int ROT  = 3;
    localparam int N    = (1 << ND) - 1;

    logic clk = 1'b0;
    logic init_a_n, init_b_n;
    always #5 clk = ~clk;

    dec2stch_bank_if #(.ND(ND), .NCH(NCH)) bus_a ();
    dec2stch_bank_if #(.ND(ND), .NCH(NCH)) bus_b ();

    dec2stch_bank #(.ND(ND), .NCH(NCH), .SEED(SEED), .ROT(ROT), .CONTINUOUS(0)) dut_a (
        .CLK(clk), .INIT_N(init_a_n), .bus(bus_a));
    dec2stch_bank #(.ND(ND), .NCH(NCH), .SEED(SEED), .ROT(ROT), .CONTINUOUS(1)) dut_b (
        .CLK(clk), .INIT_N(init_b_n), .bus(bus_b));

    typedef struct packed {
        logic [NCH-1:0] s;
        logic           fe;
    } exp_t;

    exp_t              qa[$], qb[$];
    logic [NCH*ND-1:0] ca[$], cb[$];
    int                seq[N];
    int                n_chk = 0;
    int                n_pass = 0;

    function automatic void chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    endfunction

    // Reference sequence: state i of the frame, from the feedback polynomial x^8+x^6+x^5+x^4+1.
    function automatic void build_seq();
        int s;
        s = SEED;
        for (int i = 0; i < N; i++) begin
            seq[i] = s;
            s = ((s << 1) & N) | ($countones(s & 'hB8) & 1);
        end
    endfunction

    function automatic int rot(input int x, input int r);
        return ((x << r) | (x >> (ND - r))) & N;
    endfunction

    function automatic logic [NCH*ND-1:0] mk(input int c0, input int c1);
        return {c1[ND-1:0], c0[ND-1:0]};
    endfunction

    function automatic void push_frame(input bit to_b, input logic [NCH*ND-1:0] d);
        exp_t e;
        for (int i = 0; i < N; i++) begin
            for (int k = 0; k < NCH; k++)
                e.s[k] = (int'(d[k*ND +: ND]) >= rot(seq[i], (k * ROT) % ND));
            e.fe = (i == N - 1);
            if (to_b) qb.push_back(e);
            else      qa.push_back(e);
        end
        if (to_b) cb.push_back(d);
        else      ca.push_back(d);
    endfunction

    // Monitor for the one-shot instance.
    int             ones_a[NCH];
    bit             in_a = 0, prev_fe_a = 0, done_a = 0;
    int             bits_a = 0;
    logic [NCH-1:0] last_sa = '0;
    always @(negedge clk) begin
        exp_t              e;
        logic [NCH*ND-1:0] d;
        if (prev_fe_a) chk("a_ready_after_fe", int'(bus_a.READY), 1);
        prev_fe_a = 0;
        if (bus_a.VALID === 1'b1) begin
            if (qa.size() == 0) chk("a_unexpected_bit", qa.size(), 1);
            else begin
                e = qa.pop_front();
                chk("a_bit", int'({bus_a.S, bus_a.FRAME_END}), int'(e));
            end
            for (int k = 0; k < NCH; k++) ones_a[k] += int'(bus_a.S[k]);
            bits_a++;
            last_sa = bus_a.S;
            in_a = 1;
            if (bus_a.FRAME_END) begin
                if (ca.size() == 0) chk("a_unexpected_frame", ca.size(), 1);
                else begin
                    d = ca.pop_front();
                    for (int k = 0; k < NCH; k++) chk("a_ones", ones_a[k], int'(d[k*ND +: ND]));
                end
                for (int k = 0; k < NCH; k++) ones_a[k] = 0;
                in_a = 0;
                done_a = 1;
                prev_fe_a = 1;
            end
        end else if (in_a && init_a_n) begin
            chk("a_stall_hold", int'(bus_a.S), int'(last_sa));
        end
        if (!init_a_n) in_a = 0;
    end

    // Monitor for the continuous instance.
    int ones_b[NCH];
    int cyc_b = 0, last_fe_b = 0;
    bit have_fe_b = 0;
    always @(negedge clk) begin
        exp_t              e;
        logic [NCH*ND-1:0] d;
        cyc_b++;
        if (bus_b.VALID === 1'b1) begin
            if (qb.size() == 0) chk("b_unexpected_bit", qb.size(), 1);
            else begin
                e = qb.pop_front();
                chk("b_bit", int'({bus_b.S, bus_b.FRAME_END}), int'(e));
            end
            for (int k = 0; k < NCH; k++) ones_b[k] += int'(bus_b.S[k]);
            if (bus_b.FRAME_END) begin
                if (cb.size() == 0) chk("b_unexpected_frame", cb.size(), 1);
                else begin
                    d = cb.pop_front();
                    for (int k = 0; k < NCH; k++) chk("b_ones", ones_b[k], int'(d[k*ND +: ND]));
                end
                if (have_fe_b) chk("b_frame_gap", cyc_b - last_fe_b, N);
                last_fe_b = cyc_b;
                have_fe_b = 1;
                for (int k = 0; k < NCH; k++) ones_b[k] = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_a(input logic [NCH*ND-1:0] d);
        int t;
        t = 0;
        while (!bus_a.READY && t < 2000) begin
            tick();
            t++;
        end
        if (t >= 2000) chk("a_ready_timeout", int'(bus_a.READY), 1);
        bus_a.D    = d;
        bus_a.LOAD = 1'b1;
        push_frame(0, d);
        done_a = 0;
        tick();
        bus_a.LOAD = 1'b0;
    endtask

    task automatic wait_done_a(input bit rnd_en, output int cycles);
        cycles = 0;
        while (!done_a && cycles < 4000) begin
            bus_a.EN = rnd_en ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            cycles++;
        end
        if (!done_a) chk("a_frame_timeout", int'(done_a), 1);
        bus_a.EN = 1'b1;
        tick();
    endtask

    task automatic check_idle_a(input string tag);
        chk({tag, "_ready"}, int'(bus_a.READY), 1);
        chk({tag, "_valid"}, int'(bus_a.VALID), 0);
        chk({tag, "_s"}, int'(bus_a.S), 0);
        chk({tag, "_fe"}, int'(bus_a.FRAME_END), 0);
        chk({tag, "_lfsr"}, int'(dut_a.lfsr_q), SEED);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int                cyc;
        logic [NCH*ND-1:0] cur, shadow, dnew;
        bit                pend, ld;

        build_seq();
        init_a_n = 1'b0; init_b_n = 1'b0;
        bus_a.D = '0; bus_a.LOAD = 1'b0; bus_a.EN = 1'b1;
        bus_b.D = '0; bus_b.LOAD = 1'b0; bus_b.EN = 1'b1;
        tick(); tick();
        check_idle_a("reset");
        chk("reset_b_valid", int'(bus_b.VALID), 0);
        chk("reset_b_ready", int'(bus_b.READY), 1);
        init_a_n = 1'b1; init_b_n = 1'b1;
        tick();

        // Extremes: all zeros and all ones.
        load_a(mk(8'h00, 8'hFF));
        wait_done_a(0, cyc);

        // Exact counts; a LOAD during RUN must be ignored.
        load_a(mk(8'h80, 8'h01));
        repeat (20) tick();
        bus_a.D = mk(8'h11, 8'h22); bus_a.LOAD = 1'b1;
        tick();
        bus_a.LOAD = 1'b0;
        wait_done_a(0, cyc);
        load_a(mk(8'h37, 8'hC4));
        wait_done_a(0, cyc);

        // Random stalls.
        load_a(mk(8'h80, 8'h01));
        wait_done_a(1, cyc);
        chk("stall_slower", int'(cyc > 300), 1);

        // Randomized values and enables.
        for (int r = 0; r < 3; r++) begin
            load_a(mk(int'($urandom_range(0, N)), int'($urandom_range(0, N))));
            wait_done_a(r[0], cyc);
        end

        // Reset in the middle of a frame, then a clean replay.
        load_a(mk(8'h80, 8'h5A));
        cyc = 0;
        while (bits_a < 100 && cyc < 1000) begin
            tick();
            cyc++;
        end
        chk("a_reached_bit100", int'(bits_a >= 100), 1);
        init_a_n = 1'b0;
        tick(); tick();
        check_idle_a("midreset");
        qa.delete(); ca.delete();
        for (int k = 0; k < NCH; k++) ones_a[k] = 0;
        bits_a = 0;
        init_a_n = 1'b1;
        tick();
        load_a(mk(8'h80, 8'h5A));
        wait_done_a(0, cyc);
        chk("a_queue_empty", qa.size(), 0);
        chk("a_count_queue_empty", ca.size(), 0);

        // Continuous mode with shadowed reloads.
        cur = mk(8'h40, int'($urandom_range(0, N)));
        shadow = '0;
        pend = 0;
        bus_b.D = cur; bus_b.LOAD = 1'b1;
        push_frame(1, cur);
        tick();
        for (int e = 1; e <= 4 * N; e++) begin
            ld = (e == 50) || (e == 100) || (e == 3 * N);
            if (ld) begin
                dnew = (e == 50)  ? mk(8'h10, int'($urandom_range(0, N))) :
                       (e == 100) ? mk(8'h20, int'($urandom_range(0, N))) :
                                    mk(8'h08, int'($urandom_range(0, N)));
                bus_b.D = dnew;
            end
            bus_b.LOAD = ld;
            if (e % N == 0) begin
                cur = ld ? dnew : (pend ? shadow : cur);
                pend = 0;
                if (e < 4 * N) push_frame(1, cur);
            end else if (ld) begin
                shadow = dnew;
                pend = 1;
            end
            tick();
        end
        bus_b.LOAD = 1'b0;
        bus_b.EN = 1'b0;
        tick(); tick();
        chk("b_queue_empty", qb.size(), 0);
        chk("b_count_queue_empty", cb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
